// File: rtl/glb_rr_bank_xbar.sv
// Global buffer crossbar: NUM_BANK 1R1W banks shared by write and read ports through
// per-port bank masks, per-bank round-robin arbitration and a registered read-data stage.
module glb_rr_bank_xbar #(
    parameter int NUM_BANK   = 8,
    parameter int SRAM_WIDTH = 64,
    parameter int SRAM_WORD  = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_WRPORT = 2,
    parameter int NUM_RDPORT = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          TOPGLB_CfgVld,
    input  logic [NUM_BANK*(NUM_WRPORT+NUM_RDPORT)-1:0]   TOPGLB_CfgBankFlag,
    output logic                                          GLBTOP_CfgRdy,
    input  logic [SRAM_WIDTH*NUM_WRPORT-1:0]              TOPGLB_WrDat,
    input  logic [ADDR_WIDTH*NUM_WRPORT-1:0]              TOPGLB_WrAddr,
    input  logic [NUM_WRPORT-1:0]                         TOPGLB_WrVld,
    output logic [NUM_WRPORT-1:0]                         GLBTOP_WrRdy,
    input  logic [ADDR_WIDTH*NUM_RDPORT-1:0]              TOPGLB_RdAddr,
    input  logic [NUM_RDPORT-1:0]                         TOPGLB_RdAddrVld,
    output logic [NUM_RDPORT-1:0]                         GLBTOP_RdAddrRdy,
    output logic [SRAM_WIDTH*NUM_RDPORT-1:0]              GLBTOP_RdDat,
    output logic [NUM_RDPORT-1:0]                         GLBTOP_RdDatVld,
    input  logic [NUM_RDPORT-1:0]                         TOPGLB_RdDatRdy,
    output logic [NUM_WRPORT+NUM_RDPORT-1:0]              GLBTOP_AddrErr
);

    localparam int NP  = NUM_WRPORT + NUM_RDPORT;
    localparam int DW  = $clog2(SRAM_WORD);
    localparam int BW  = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int RBW = ADDR_WIDTH - DW;
    localparam int WPW = (NUM_WRPORT > 1) ? $clog2(NUM_WRPORT) : 1;
    localparam int RPW = (NUM_RDPORT > 1) ? $clog2(NUM_RDPORT) : 1;

    // Handshake: a beat transfers on a cycle where Vld & Rdy are both high. Vld must not
    // depend on Rdy; Rdy here is a combinational function of Vld (request/grant path).

    logic [NUM_BANK*NP-1:0]                  cfg_mask;
    logic [NP-1:0]                           addr_err;
    logic [NP-1:0]                           err_set;
    logic                                    cfg_rdy;
    logic                                    cfg_load;

    logic [NUM_WRPORT-1:0][BW-1:0]           wr_bank;
    logic [NUM_WRPORT-1:0][DW-1:0]           wr_word;
    logic [NUM_WRPORT-1:0]                   wr_hit;
    logic [NUM_WRPORT-1:0]                   wr_gnt;
    logic [NUM_WRPORT-1:0]                   wr_hs;
    logic [NUM_BANK-1:0][NUM_WRPORT-1:0]     wr_req;
    logic [NUM_BANK-1:0]                     wr_bank_act;
    logic [NUM_BANK-1:0][WPW-1:0]            wr_bank_win;
    logic [NUM_BANK-1:0][WPW-1:0]            wr_ptr;
    logic [NUM_BANK-1:0][DW-1:0]             wr_bank_word;
    logic [NUM_BANK-1:0][SRAM_WIDTH-1:0]     wr_bank_dat;

    logic [NUM_RDPORT-1:0][BW-1:0]           rd_bank;
    logic [NUM_RDPORT-1:0][DW-1:0]           rd_word;
    logic [NUM_RDPORT-1:0]                   rd_hit;
    logic [NUM_RDPORT-1:0]                   rd_free;
    logic [NUM_RDPORT-1:0]                   rd_gnt;
    logic [NUM_RDPORT-1:0]                   rd_hs;
    logic [NUM_BANK-1:0][NUM_RDPORT-1:0]     rd_req;
    logic [NUM_BANK-1:0]                     rd_bank_act;
    logic [NUM_BANK-1:0][RPW-1:0]            rd_bank_win;
    logic [NUM_BANK-1:0][RPW-1:0]            rd_ptr;

    logic [NUM_RDPORT-1:0]                   rd_vld;
    logic [NUM_RDPORT-1:0][SRAM_WIDTH-1:0]   rd_dat;

    logic [SRAM_WIDTH-1:0]                   mem [NUM_BANK][SRAM_WORD];

    // Returns {hit, bank}: bank is the rb-th set bit of mask, counted from bit 0.
    function automatic logic [BW:0] map_bank(input logic [NUM_BANK-1:0] mask,
                                             input logic [RBW-1:0]      rb);
        logic [RBW:0] cnt;
        logic [BW:0]  res;
        cnt = '0;
        res = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (mask[b]) begin
                if (cnt == {1'b0, rb} && !res[BW]) res = {1'b1, BW'(b)};
                cnt = cnt + (RBW+1)'(1);
            end
        end
        return res;
    endfunction

    always_comb begin
        wr_bank = '0;
        wr_word = '0;
        wr_hit  = '0;
        rd_bank = '0;
        rd_word = '0;
        rd_hit  = '0;
        for (int p = 0; p < NUM_WRPORT; p++) begin
            {wr_hit[p], wr_bank[p]} = map_bank(cfg_mask[p*NUM_BANK +: NUM_BANK],
                                               TOPGLB_WrAddr[p*ADDR_WIDTH+DW +: RBW]);
            wr_word[p] = TOPGLB_WrAddr[p*ADDR_WIDTH +: DW];
        end
        for (int q = 0; q < NUM_RDPORT; q++) begin
            {rd_hit[q], rd_bank[q]} = map_bank(cfg_mask[(NUM_WRPORT+q)*NUM_BANK +: NUM_BANK],
                                               TOPGLB_RdAddr[q*ADDR_WIDTH+DW +: RBW]);
            rd_word[q] = TOPGLB_RdAddr[q*ADDR_WIDTH +: DW];
        end
    end

    // A read port whose output register cannot take data does not request, so a stalled
    // consumer never holds a bank's grant away from the other read ports.
    always_comb begin
        rd_free = ~rd_vld | TOPGLB_RdDatRdy;
        wr_req  = '0;
        rd_req  = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int p = 0; p < NUM_WRPORT; p++)
                wr_req[b][p] = TOPGLB_WrVld[p] & wr_hit[p] & (wr_bank[p] == BW'(b));
            for (int q = 0; q < NUM_RDPORT; q++)
                rd_req[b][q] = TOPGLB_RdAddrVld[q] & rd_hit[q] & rd_free[q] & (rd_bank[q] == BW'(b));
        end
    end

    always_comb begin
        int wp;
        wp           = 0;
        wr_gnt       = '0;
        wr_bank_act  = '0;
        wr_bank_win  = '0;
        wr_bank_word = '0;
        wr_bank_dat  = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int i = 0; i < NUM_WRPORT; i++) begin
                wp = (int'(wr_ptr[b]) + i) % NUM_WRPORT;
                if (!wr_bank_act[b] && wr_req[b][wp]) begin
                    wr_bank_act[b] = 1'b1;
                    wr_bank_win[b] = WPW'(wp);
                end
            end
            for (int p = 0; p < NUM_WRPORT; p++) begin
                if (wr_bank_act[b] && wr_bank_win[b] == WPW'(p)) begin
                    wr_gnt[p]       = 1'b1;
                    wr_bank_word[b] = wr_word[p];
                    wr_bank_dat[b]  = TOPGLB_WrDat[p*SRAM_WIDTH +: SRAM_WIDTH];
                end
            end
        end
    end

    always_comb begin
        int rp;
        rp          = 0;
        rd_gnt      = '0;
        rd_bank_act = '0;
        rd_bank_win = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int i = 0; i < NUM_RDPORT; i++) begin
                rp = (int'(rd_ptr[b]) + i) % NUM_RDPORT;
                if (!rd_bank_act[b] && rd_req[b][rp]) begin
                    rd_bank_act[b] = 1'b1;
                    rd_bank_win[b] = RPW'(rp);
                end
            end
            for (int q = 0; q < NUM_RDPORT; q++)
                if (rd_bank_act[b] && rd_bank_win[b] == RPW'(q)) rd_gnt[q] = 1'b1;
        end
    end

    // Out-of-range beats complete without a grant so a misaddressed port cannot deadlock.
    always_comb begin
        wr_hs   = TOPGLB_WrVld & ((wr_hit & wr_gnt) | ~wr_hit);
        rd_hs   = TOPGLB_RdAddrVld & rd_free & ((rd_hit & rd_gnt) | ~rd_hit);
        err_set = {TOPGLB_RdAddrVld & rd_free & ~rd_hit, TOPGLB_WrVld & ~wr_hit};
        cfg_rdy = ~|rd_vld;
        cfg_load = TOPGLB_CfgVld & cfg_rdy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (wr_bank_act[b])
                    wr_ptr[b] <= (int'(wr_bank_win[b]) == NUM_WRPORT-1) ? '0 : wr_bank_win[b] + WPW'(1);
                if (rd_bank_act[b])
                    rd_ptr[b] <= (int'(rd_bank_win[b]) == NUM_RDPORT-1) ? '0 : rd_bank_win[b] + RPW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANK; b++)
            if (wr_bank_act[b]) mem[b][wr_bank_word[b]] <= wr_bank_dat[b];
    end

    // Reading mem with non-blocking semantics returns the pre-write word on a same-cycle collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= '0;
            rd_dat <= '0;
        end else begin
            for (int q = 0; q < NUM_RDPORT; q++) begin
                if (rd_hs[q]) begin
                    rd_vld[q] <= 1'b1;
                    rd_dat[q] <= rd_hit[q] ? mem[rd_bank[q]][rd_word[q]] : '0;
                end else if (TOPGLB_RdDatRdy[q]) begin
                    rd_vld[q] <= 1'b0;
                end
            end
        end
    end

    // Errors raised under the old masks are discarded by the load that replaces them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mask <= '0;
            addr_err <= '0;
        end else if (cfg_load) begin
            cfg_mask <= TOPGLB_CfgBankFlag;
            addr_err <= '0;
        end else begin
            addr_err <= addr_err | err_set;
        end
    end

    assign GLBTOP_CfgRdy    = rst_n & cfg_rdy;
    assign GLBTOP_WrRdy     = {NUM_WRPORT{rst_n}} & wr_hs;
    assign GLBTOP_RdAddrRdy = {NUM_RDPORT{rst_n}} & rd_hs;
    assign GLBTOP_RdDat     = rd_dat;
    assign GLBTOP_RdDatVld  = rd_vld;
    assign GLBTOP_AddrErr   = addr_err;

endmodule

// File: tb/tb_glb_rr_bank_xbar.sv
// Directed bench for glb_rr_bank_xbar: round-robin, bank mapping, backpressure,
// collision, out-of-range, config gating and asynchronous reset.
module tb_glb_rr_bank_xbar;

    localparam int NB = 8;
    localparam int SW = 64;
    localparam int AW = 16;
    localparam int NW = 2;
    localparam int NR = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cfg_vld;
    logic [NB*(NW+NR)-1:0]  cfg_flag;
    logic                   cfg_rdy;
    logic [SW*NW-1:0]       wr_dat;
    logic [AW*NW-1:0]       wr_addr;
    logic [NW-1:0]          wr_vld;
    logic [NW-1:0]          wr_rdy;
    logic [AW*NR-1:0]       rd_addr;
    logic [NR-1:0]          rd_addr_vld;
    logic [NR-1:0]          rd_addr_rdy;
    logic [SW*NR-1:0]       rd_dat;
    logic [NR-1:0]          rd_dat_vld;
    logic [NR-1:0]          rd_dat_rdy;
    logic [NW+NR-1:0]       addr_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    glb_rr_bank_xbar dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .TOPGLB_CfgVld      (cfg_vld),
        .TOPGLB_CfgBankFlag (cfg_flag),
        .GLBTOP_CfgRdy      (cfg_rdy),
        .TOPGLB_WrDat       (wr_dat),
        .TOPGLB_WrAddr      (wr_addr),
        .TOPGLB_WrVld       (wr_vld),
        .GLBTOP_WrRdy       (wr_rdy),
        .TOPGLB_RdAddr      (rd_addr),
        .TOPGLB_RdAddrVld   (rd_addr_vld),
        .GLBTOP_RdAddrRdy   (rd_addr_rdy),
        .GLBTOP_RdDat       (rd_dat),
        .GLBTOP_RdDatVld    (rd_dat_vld),
        .TOPGLB_RdDatRdy    (rd_dat_rdy),
        .GLBTOP_AddrErr     (addr_err)
    );

    // Inputs change 1 time unit after posedge; checks happen on the following negedge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_vld     = 1'b0;
        cfg_flag    = '0;
        wr_dat      = '0;
        wr_addr     = '0;
        wr_vld      = '0;
        rd_addr     = '0;
        rd_addr_vld = '0;
        rd_dat_rdy  = '1;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [SW-1:0] d);
        wr_addr[p*AW +: AW] = a;
        wr_dat[p*SW +: SW]  = d;
    endtask

    task automatic set_rd(input int q, input logic [AW-1:0] a);
        rd_addr[q*AW +: AW] = a;
    endtask

    task automatic load_cfg(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] r0, input logic [7:0] r1);
        cfg_flag = {r1, r0, w1, w0};
        cfg_vld  = 1'b1;
        #2;
        total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL load_cfg_rdy: got %b want 1", cfg_rdy); end
        cyc();
        cfg_vld = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n       = 1'b0;
        wr_vld      = 2'b11;
        rd_addr_vld = 2'b11;
        cfg_vld     = 1'b1;
        cyc();
        cyc();
        total++; if (wr_rdy !== 2'b00) begin bad++; $display("FAIL rst_wr_rdy: got %b want 00", wr_rdy); end
        total++; if (rd_addr_rdy !== 2'b00) begin bad++; $display("FAIL rst_rd_rdy: got %b want 00", rd_addr_rdy); end
        total++; if (cfg_rdy !== 1'b0) begin bad++; $display("FAIL rst_cfg_rdy: got %b want 0", cfg_rdy); end
        total++; if (rd_dat_vld !== 2'b00) begin bad++; $display("FAIL rst_dat_vld: got %b want 00", rd_dat_vld); end
        total++; if (rd_dat !== '0) begin bad++; $display("FAIL rst_rd_dat: got %h want 0", rd_dat); end
        total++; if (addr_err !== 4'b0000) begin bad++; $display("FAIL rst_addr_err: got %b want 0000", addr_err); end
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        #4;
        total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL post_rst_cfg_rdy: got %b want 1", cfg_rdy); end
        total++; if (wr_rdy !== 2'b00) begin bad++; $display("FAIL post_rst_wr_rdy: got %b want 00", wr_rdy); end
        cyc();
    endtask

    task automatic test_rr_write();
        logic [1:0] exp_seq [4];
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        load_cfg(8'h01, 8'h01, 8'h00, 8'h00);
        set_wr(0, 16'd0, 64'h100);
        set_wr(1, 16'd1, 64'h200);
        wr_vld = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #4;
            total++; if (wr_rdy !== exp_seq[i]) begin bad++; $display("FAIL rr_write[%0d]: got %b want %b", i, wr_rdy, exp_seq[i]); end
            cyc();
        end
        wr_vld = 2'b00;
        cyc();
    endtask

    task automatic test_linear_map();
        logic [SW-1:0] x, y;
        x = 64'hAAAA_0000_0000_0005;
        y = 64'hBBBB_0000_0000_0045;
        load_cfg(8'h0C, 8'h00, 8'h0C, 8'h00);
        set_wr(0, 16'd5, x);
        wr_vld = 2'b01;
        #4;
        total++; if (wr_rdy !== 2'b01) begin bad++; $display("FAIL map_wr5_rdy: got %b want 01", wr_rdy); end
        cyc();
        set_wr(0, 16'd69, y);
        #4;
        total++; if (wr_rdy !== 2'b01) begin bad++; $display("FAIL map_wr69_rdy: got %b want 01", wr_rdy); end
        cyc();
        wr_vld = 2'b00;
        set_rd(0, 16'd5);
        rd_addr_vld = 2'b01;
        #4;
        total++; if (rd_addr_rdy !== 2'b01) begin bad++; $display("FAIL map_rd5_rdy: got %b want 01", rd_addr_rdy); end
        cyc();
        set_rd(0, 16'd69);
        #4;
        total++; if (rd_dat_vld !== 2'b01) begin bad++; $display("FAIL map_rd5_vld: got %b want 01", rd_dat_vld); end
        total++; if (rd_dat[SW-1:0] !== x) begin bad++; $display("FAIL map_rd5_dat: got %h want %h", rd_dat[SW-1:0], x); end
        total++; if (rd_addr_rdy !== 2'b01) begin bad++; $display("FAIL map_rd69_rdy: got %b want 01", rd_addr_rdy); end
        cyc();
        rd_addr_vld = 2'b00;
        #4;
        total++; if (rd_dat[SW-1:0] !== y) begin bad++; $display("FAIL map_rd69_dat: got %h want %h", rd_dat[SW-1:0], y); end
        cyc();
        // Single-bank masks pin down which physical bank holds each word.
        load_cfg(8'h00, 8'h00, 8'h04, 8'h00);
        set_rd(0, 16'd5);
        rd_addr_vld = 2'b01;
        cyc();
        rd_addr_vld = 2'b00;
        #4;
        total++; if (rd_dat[SW-1:0] !== x) begin bad++; $display("FAIL map_bank2_dat: got %h want %h", rd_dat[SW-1:0], x); end
        cyc();
        load_cfg(8'h00, 8'h00, 8'h08, 8'h00);
        rd_addr_vld = 2'b01;
        cyc();
        rd_addr_vld = 2'b00;
        #4;
        total++; if (rd_dat[SW-1:0] !== y) begin bad++; $display("FAIL map_bank3_dat: got %h want %h", rd_dat[SW-1:0], y); end
        cyc();
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] exp_q[$];
        logic          m_vld;
        logic          datrdy;
        logic          exp_rdy;
        int            idx;
        int            consumed_n;
        m_vld      = 1'b0;
        idx        = 0;
        consumed_n = 0;
        load_cfg(8'h01, 8'h00, 8'h01, 8'h00);
        wr_vld = 2'b01;
        for (int i = 0; i < 4; i++) begin
            set_wr(0, AW'(i), 64'h5000 + 64'(i));
            cyc();
        end
        wr_vld = 2'b00;
        for (int c = 0; c < 10; c++) begin
            datrdy         = !(c >= 2 && c <= 4);
            rd_dat_rdy[0]  = datrdy;
            rd_addr_vld[0] = (idx < 4);
            set_rd(0, AW'(idx));
            #4;
            exp_rdy = (idx < 4) && (!m_vld || datrdy);
            total++; if (rd_addr_rdy[0] !== exp_rdy) begin bad++; $display("FAIL bp_rdy[%0d]: got %b want %b", c, rd_addr_rdy[0], exp_rdy); end
            total++; if (rd_dat_vld[0] !== m_vld) begin bad++; $display("FAIL bp_vld[%0d]: got %b want %b", c, rd_dat_vld[0], m_vld); end
            if (m_vld && exp_q.size() > 0) begin
                total++; if (rd_dat[SW-1:0] !== exp_q[0]) begin bad++; $display("FAIL bp_dat[%0d]: got %h want %h", c, rd_dat[SW-1:0], exp_q[0]); end
            end
            if (m_vld && datrdy) begin
                void'(exp_q.pop_front());
                consumed_n++;
                m_vld = 1'b0;
            end
            if (exp_rdy) begin
                exp_q.push_back(64'h5000 + 64'(idx));
                idx++;
                m_vld = 1'b1;
            end
            cyc();
        end
        rd_addr_vld = 2'b00;
        rd_dat_rdy  = 2'b11;
        total++; if (consumed_n != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", consumed_n); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
        cyc();
    endtask

    task automatic test_collision();
        set_wr(0, 16'd7, 64'hA);
        wr_vld = 2'b01;
        cyc();
        set_wr(0, 16'd7, 64'hB);
        set_rd(0, 16'd7);
        rd_addr_vld = 2'b01;
        #4;
        total++; if (wr_rdy !== 2'b01) begin bad++; $display("FAIL coll_wr_rdy: got %b want 01", wr_rdy); end
        total++; if (rd_addr_rdy !== 2'b01) begin bad++; $display("FAIL coll_rd_rdy: got %b want 01", rd_addr_rdy); end
        cyc();
        wr_vld = 2'b00;
        #4;
        total++; if (rd_dat[SW-1:0] !== 64'hA) begin bad++; $display("FAIL coll_old: got %h want %h", rd_dat[SW-1:0], 64'hA); end
        cyc();
        rd_addr_vld = 2'b00;
        #4;
        total++; if (rd_dat[SW-1:0] !== 64'hB) begin bad++; $display("FAIL coll_new: got %h want %h", rd_dat[SW-1:0], 64'hB); end
        cyc();
        cyc();
    endtask

    task automatic test_rr_read();
        logic [1:0]    exp_seq [4];
        logic [SW-1:0] r;
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        r = 64'hCAFE_0003;
        load_cfg(8'h02, 8'h00, 8'h02, 8'h02);
        set_wr(0, 16'd3, r);
        wr_vld = 2'b01;
        cyc();
        wr_vld = 2'b00;
        set_rd(0, 16'd3);
        set_rd(1, 16'd3);
        rd_addr_vld = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #4;
            total++; if (rd_addr_rdy !== exp_seq[i]) begin bad++; $display("FAIL rr_read[%0d]: got %b want %b", i, rd_addr_rdy, exp_seq[i]); end
            if (i > 0) begin
                total++; if (rd_dat_vld !== exp_seq[i-1]) begin bad++; $display("FAIL rr_read_vld[%0d]: got %b want %b", i, rd_dat_vld, exp_seq[i-1]); end
                total++; if (rd_dat[(i-1)%2*SW +: SW] !== r) begin bad++; $display("FAIL rr_read_dat[%0d]: got %h want %h", i, rd_dat[(i-1)%2*SW +: SW], r); end
            end
            cyc();
        end
        rd_addr_vld = 2'b00;
        cyc();
        cyc();
    endtask

    task automatic test_out_of_range();
        logic [SW-1:0] c;
        c = 64'hC0C0_0000;
        load_cfg(8'h00, 8'h10, 8'h10, 8'h00);
        set_wr(1, 16'd0, c);
        wr_vld = 2'b10;
        #4;
        total++; if (wr_rdy !== 2'b10) begin bad++; $display("FAIL oor_pre_rdy: got %b want 10", wr_rdy); end
        cyc();
        set_wr(1, 16'd64, 64'hDEAD);
        #4;
        total++; if (wr_rdy !== 2'b10) begin bad++; $display("FAIL oor_wr_rdy: got %b want 10", wr_rdy); end
        total++; if (addr_err !== 4'b0000) begin bad++; $display("FAIL oor_err_early: got %b want 0000", addr_err); end
        cyc();
        wr_vld = 2'b00;
        #4;
        total++; if (addr_err !== 4'b0010) begin bad++; $display("FAIL oor_err_set: got %b want 0010", addr_err); end
        cyc();
        set_rd(0, 16'd0);
        rd_addr_vld = 2'b01;
        cyc();
        rd_addr_vld = 2'b00;
        #4;
        total++; if (rd_dat[SW-1:0] !== c) begin bad++; $display("FAIL oor_bank_kept: got %h want %h", rd_dat[SW-1:0], c); end
        cyc();
        cyc();
        total++; if (addr_err !== 4'b0010) begin bad++; $display("FAIL oor_err_sticky: got %b want 0010", addr_err); end
        set_rd(0, 16'd64);
        rd_addr_vld = 2'b01;
        #4;
        total++; if (rd_addr_rdy !== 2'b01) begin bad++; $display("FAIL oor_rd_rdy: got %b want 01", rd_addr_rdy); end
        cyc();
        rd_addr_vld = 2'b00;
        #4;
        total++; if (rd_dat_vld !== 2'b01) begin bad++; $display("FAIL oor_rd_vld: got %b want 01", rd_dat_vld); end
        total++; if (rd_dat[SW-1:0] !== '0) begin bad++; $display("FAIL oor_rd_dat: got %h want 0", rd_dat[SW-1:0]); end
        total++; if (addr_err !== 4'b0110) begin bad++; $display("FAIL oor_rd_err: got %b want 0110", addr_err); end
        cyc();
        load_cfg(8'h00, 8'h10, 8'h10, 8'h00);
        #2;
        total++; if (addr_err !== 4'b0000) begin bad++; $display("FAIL oor_err_clear: got %b want 0000", addr_err); end
        cyc();
    endtask

    task automatic test_cfg_ignored();
        logic [SW-1:0] c;
        c = 64'hC0C0_0000;
        rd_dat_rdy[0] = 1'b0;
        set_rd(0, 16'd0);
        rd_addr_vld = 2'b01;
        cyc();
        rd_addr_vld = 2'b00;
        #4;
        total++; if (rd_dat_vld[0] !== 1'b1) begin bad++; $display("FAIL cfgign_vld: got %b want 1", rd_dat_vld[0]); end
        total++; if (cfg_rdy !== 1'b0) begin bad++; $display("FAIL cfgign_rdy: got %b want 0", cfg_rdy); end
        cyc();
        cfg_flag = '0;
        cfg_vld  = 1'b1;
        cyc();
        cfg_vld       = 1'b0;
        rd_dat_rdy[0] = 1'b1;
        #4;
        total++; if (rd_dat[SW-1:0] !== c) begin bad++; $display("FAIL cfgign_hold: got %h want %h", rd_dat[SW-1:0], c); end
        cyc();
        rd_addr_vld = 2'b01;
        #4;
        total++; if (rd_addr_rdy !== 2'b01) begin bad++; $display("FAIL cfgign_rd_rdy: got %b want 01", rd_addr_rdy); end
        cyc();
        rd_addr_vld = 2'b00;
        #4;
        total++; if (rd_dat[SW-1:0] !== c) begin bad++; $display("FAIL cfgign_dat: got %h want %h", rd_dat[SW-1:0], c); end
        total++; if (addr_err !== 4'b0000) begin bad++; $display("FAIL cfgign_err: got %b want 0000", addr_err); end
        cyc();
    endtask

    task automatic test_reset_mid();
        rd_dat_rdy[0] = 1'b0;
        set_rd(0, 16'd0);
        rd_addr_vld = 2'b01;
        cyc();
        set_wr(1, 16'd0, 64'h77);
        wr_vld = 2'b10;
        #2;
        total++; if (wr_rdy !== 2'b10) begin bad++; $display("FAIL midrst_pre_wr: got %b want 10", wr_rdy); end
        total++; if (rd_dat_vld !== 2'b01) begin bad++; $display("FAIL midrst_pre_vld: got %b want 01", rd_dat_vld); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (wr_rdy !== 2'b00) begin bad++; $display("FAIL midrst_wr_rdy: got %b want 00", wr_rdy); end
        total++; if (rd_addr_rdy !== 2'b00) begin bad++; $display("FAIL midrst_rd_rdy: got %b want 00", rd_addr_rdy); end
        total++; if (rd_dat_vld !== 2'b00) begin bad++; $display("FAIL midrst_vld: got %b want 00", rd_dat_vld); end
        total++; if (cfg_rdy !== 1'b0) begin bad++; $display("FAIL midrst_cfg_rdy: got %b want 0", cfg_rdy); end
        total++; if (rd_dat !== '0) begin bad++; $display("FAIL midrst_dat: got %h want 0", rd_dat); end
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        #4;
        total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL midrst_release: got %b want 1", cfg_rdy); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_rr_write();
        test_linear_map();
        test_backpressure();
        test_collision();
        test_rr_read();
        test_out_of_range();
        test_cfg_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
